// File: rtl/w_161_timer_ctrl.sv
// w_161_timer_ctrl
// Sequencer for a cascaded chain of 74HC161-style 4-bit counters forming a
// WIDTH-bit up counter. Drives the shared PE_N/CEP/CET/D/CLR_N lines and
// watches the chain's final TC to build a programmable-period timer with
// one-shot and auto-reload modes, hold, and TICK/DONE reporting.
//
// The chain is loaded with 2^WIDTH - PERIOD so that it reaches all-ones after
// PERIOD-1 enabled counts; the next enabled count is the expiry.
//
// Optional build macro: W161_CTRL_PRESCALE_EN
//   When defined, CEP is additionally gated by a modulo-PRESCALE strobe so
//   the timer period becomes PERIOD*PRESCALE clock cycles.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | stopped; chain frozen, waiting for START
// S_LOAD | one cycle with PE_N low; the chain takes D at the next edge
// S_RUN  | chain counting; expiry reloads (auto) or finishes (one-shot)
// S_DONE | one-shot expired; chain frozen, DONE high until restart/stop

module w_161_timer_ctrl #(
  parameter int NIBBLES  = 2,
  parameter int PRESCALE = 4,
  localparam int WIDTH   = 4 * NIBBLES
) (
  input  logic             CP,
  input  logic             MR_N,
  input  logic             START,
  input  logic             STOP,
  input  logic             HOLD,
  input  logic             MODE,
  input  logic [WIDTH-1:0] PERIOD,
  input  logic             TC_IN,
  output logic             PE_N,
  output logic             CEP,
  output logic             CET,
  output logic [WIDTH-1:0] D,
  output logic             CLR_N,
  output logic             TICK,
  output logic             DONE,
  output logic             BUSY
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  if (PRESCALE < 1 || PRESCALE > 255) begin : g_prescale_range
    $error("w_161_timer_ctrl: PRESCALE must be within 1..255");
  end

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] per_q;
  logic             tick_q;
  logic             done_q;
  logic             clr_n_q;
  logic             strobe;
  logic             expiry;
  logic             pe_n_c;
  logic             cep_c;
  logic             cet_c;
  logic             load_per;

`ifdef W161_CTRL_PRESCALE_EN
  logic [7:0] psc_q;

  assign strobe = (psc_q == 8'(PRESCALE - 1));

  // Prescale counter: counts only while staying in RUN, frozen by HOLD,
  // and forced to zero everywhere else so each LOAD starts a fresh divide.
  always_ff @(posedge CP or negedge MR_N) begin
    if (!MR_N) begin
      psc_q <= 8'd0;
    end else if (state_q == S_RUN && state_d == S_RUN) begin
      if (!HOLD) begin
        psc_q <= strobe ? 8'd0 : psc_q + 8'd1;
      end
    end else begin
      psc_q <= 8'd0;
    end
  end
`else
  assign strobe = 1'b1;
`endif

  // Next-state and chain control; the reload PE_N is combinational so it
  // overrides the chain's wrap on the very edge that expires.
  always_comb begin
    state_d = state_q;
    pe_n_c  = 1'b1;
    cep_c   = 1'b0;
    cet_c   = 1'b0;
    expiry  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START) state_d = S_LOAD;
      end
      S_LOAD: begin
        pe_n_c  = 1'b0;
        state_d = S_RUN;
      end
      S_RUN: begin
        cet_c  = 1'b1;
        cep_c  = ~HOLD & strobe;
        expiry = TC_IN & cep_c;
        pe_n_c = ~(expiry & MODE);
        if (START) begin
          state_d = S_LOAD;
        end else if (expiry) begin
          state_d = MODE ? S_RUN : S_DONE;
        end
      end
      S_DONE: begin
        if (START) state_d = S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
    if (STOP) state_d = S_IDLE;
  end

  assign load_per = (state_d == S_LOAD) && (state_q != S_LOAD);

  // State, latched period and registered status outputs.
  always_ff @(posedge CP or negedge MR_N) begin
    if (!MR_N) begin
      state_q <= S_IDLE;
      per_q   <= '0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
      clr_n_q <= 1'b1;
    end else begin
      state_q <= state_d;
      if (load_per) per_q <= PERIOD;
      tick_q  <= expiry;
      done_q  <= (state_d == S_DONE);
      clr_n_q <= ~(STOP && state_q != S_IDLE);
    end
  end

  assign D     = ~per_q + WIDTH'(1);
  assign PE_N  = pe_n_c;
  assign CEP   = cep_c;
  assign CET   = cet_c;
  assign CLR_N = clr_n_q;
  assign TICK  = tick_q;
  assign DONE  = done_q;
  assign BUSY  = (state_q == S_LOAD) || (state_q == S_RUN);

endmodule

// File: tb/tb_w_161_timer_ctrl.sv
// Bench for w_161_timer_ctrl: models an 8-bit 74HC161 chain around the
// controller, queues the expected TICK cycle numbers as each run is started,
// and lets an independent monitor pop and compare on every TICK.
// Build with W161_CTRL_PRESCALE_EN to exercise the prescaled timing.

module tb_w_161_timer_ctrl;

  localparam int NIBBLES  = 2;
  localparam int WIDTH    = 8;
  localparam int PRESCALE = 4;
`ifdef W161_CTRL_PRESCALE_EN
  localparam int PS = PRESCALE;
`else
  localparam int PS = 1;
`endif

  logic             CP     = 1'b0;
  logic             MR_N   = 1'b1;
  logic             START  = 1'b0;
  logic             STOP   = 1'b0;
  logic             HOLD   = 1'b0;
  logic             MODE   = 1'b0;
  logic [WIDTH-1:0] PERIOD = '0;
  logic             TC_IN;
  logic             PE_N;
  logic             CEP;
  logic             CET;
  logic [WIDTH-1:0] D;
  logic             CLR_N;
  logic             TICK;
  logic             DONE;
  logic             BUSY;

  logic [WIDTH-1:0] q;
  int cyc         = 0;
  int vectors     = 0;
  int miscompares = 0;
  int exp_q[$];
  int mon_e;

  w_161_timer_ctrl #(.NIBBLES(NIBBLES), .PRESCALE(PRESCALE)) dut (
    .CP(CP), .MR_N(MR_N), .START(START), .STOP(STOP), .HOLD(HOLD),
    .MODE(MODE), .PERIOD(PERIOD), .TC_IN(TC_IN), .PE_N(PE_N), .CEP(CEP),
    .CET(CET), .D(D), .CLR_N(CLR_N), .TICK(TICK), .DONE(DONE), .BUSY(BUSY)
  );

  always #5 CP = ~CP;

  always @(posedge CP) cyc <= cyc + 1;

  // Counter chain: cleared by board reset or CLR_N, load beats count.
  always @(posedge CP or negedge MR_N or negedge CLR_N) begin
    if (!MR_N || !CLR_N) q <= '0;
    else if (!PE_N) q <= D;
    else if (CEP && CET) q <= q + WIDTH'(1);
  end
  assign TC_IN = CET & (&q);

  // Monitor: every TICK must match the oldest expected cycle number.
  always @(negedge CP) begin
    if (MR_N && TICK === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL tick_unexpected: TICK high at cycle %0d, none expected", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e != cyc) begin
          miscompares++;
          $display("FAIL tick_time: TICK at cycle %0d, expected cycle %0d", cyc, mon_e);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CP);
    #1;
  endtask

  task automatic go_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, want %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk8(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic drained(input string nm);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s: %0d expected TICKs never seen, next at cycle %0d", nm, exp_q.size(), exp_q[0]);
      exp_q.delete();
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk1({tag, "_pe_n"},  PE_N,  1'b1);
    chk1({tag, "_cep"},   CEP,   1'b0);
    chk1({tag, "_cet"},   CET,   1'b0);
    chk8({tag, "_d"},     D,     8'h00);
    chk1({tag, "_clr_n"}, CLR_N, 1'b1);
    chk1({tag, "_tick"},  TICK,  1'b0);
    chk1({tag, "_done"},  DONE,  1'b0);
    chk1({tag, "_busy"},  BUSY,  1'b0);
  endtask

  // Drive START for one sampled edge; c is the cycle number at issue time.
  task automatic kick(input logic m, input logic [WIDTH-1:0] p, output int c);
    MODE   = m;
    PERIOD = p;
    START  = 1'b1;
    c      = cyc;
    step();
    START  = 1'b0;
  endtask

  initial begin
    int c;
    int t;
    int e1;
    int last;

    // Reset values
    #2 MR_N = 1'b0;
    #1 chk_reset_vals("reset");
    go_to(2);
    MR_N = 1'b1;
    go_to(4);

    // Auto-reload, PERIOD=5
    kick(1'b1, 8'd5, c);
    chk1("t1_load_pe_n", PE_N, 1'b0);
    chk8("t1_load_d",    D,    8'hFB);
    chk1("t1_load_busy", BUSY, 1'b1);
    chk1("t1_load_cep",  CEP,  1'b0);
    chk1("t1_load_cet",  CET,  1'b0);
    for (int k = 0; k < 3; k++) exp_q.push_back(c + 2 + 5*PS + k*5*PS);
    go_to(c + 1 + 5*PS);
    chk1("t1_reload_pe_n_1", PE_N, 1'b0);
    go_to(c + 1 + 10*PS);
    chk1("t1_reload_pe_n_2", PE_N, 1'b0);
    go_to(c + 3 + 15*PS);
    STOP = 1'b1;
    step();
    STOP = 1'b0;
    chk1("t1_stop_clr_n", CLR_N, 1'b0);
    chk1("t1_stop_busy",  BUSY,  1'b0);
    step();
    chk1("t1_stop_clr_n_release", CLR_N, 1'b1);
    drained("t1_ticks");

    // One-shot, PERIOD=3, then restart from DONE
    kick(1'b0, 8'd3, c);
    t = c + 2 + 3*PS;
    exp_q.push_back(t);
    go_to(t - 1);
    chk1("t2_pre_done", DONE, 1'b0);
    chk1("t2_pre_busy", BUSY, 1'b1);
    go_to(t);
    chk1("t2_done",  DONE, 1'b1);
    chk1("t2_busy",  BUSY, 1'b0);
    chk1("t2_cep",   CEP,  1'b0);
    chk1("t2_cet",   CET,  1'b0);
    chk1("t2_pe_n",  PE_N, 1'b1);
    go_to(t + 3);
    chk1("t2_done_held", DONE, 1'b1);
    chk1("t2_cep_held",  CEP,  1'b0);
    drained("t2_ticks");
    kick(1'b0, 8'd3, c);
    chk1("t2_restart_done", DONE, 1'b0);
    chk1("t2_restart_busy", BUSY, 1'b1);
    t = c + 2 + 3*PS;
    exp_q.push_back(t);
    go_to(t);
    chk1("t2_restart_done_again", DONE, 1'b1);
    go_to(t + 1);
    drained("t2_restart_ticks");

    // Auto-reload PERIOD=10 with HOLD for 4 cycles at all-ones
    kick(1'b1, 8'd10, c);
    e1 = c + 2 + 10*PS;
    exp_q.push_back(e1 + 4);
    exp_q.push_back(e1 + 4 + 10*PS);
    go_to(e1 - 1);
    HOLD = 1'b1;
    go_to(e1);
    chk1("t3_hold_cep",   CEP,   1'b0);
    chk1("t3_hold_cet",   CET,   1'b1);
    chk1("t3_hold_tc",    TC_IN, 1'b1);
    chk1("t3_hold_tick",  TICK,  1'b0);
    chk1("t3_hold_pe_n",  PE_N,  1'b1);
    go_to(e1 + 3);
    HOLD = 1'b0;
    go_to(e1 + 5 + 10*PS);
    drained("t3_ticks");

    // START and STOP together in RUN: STOP wins
    MODE   = 1'b1;
    PERIOD = 8'd7;
    START  = 1'b1;
    STOP   = 1'b1;
    step();
    START  = 1'b0;
    STOP   = 1'b0;
    chk1("t4_clr_n", CLR_N, 1'b0);
    chk1("t4_busy",  BUSY,  1'b0);
    chk1("t4_tick",  TICK,  1'b0);
    chk1("t4_pe_n",  PE_N,  1'b1);
    step();
    chk1("t4_clr_n_one_cycle", CLR_N, 1'b1);
    chk1("t4_busy_idle",       BUSY,  1'b0);
    go_to(cyc + 20);
    drained("t4_ticks");

    // PERIOD=0 (2^WIDTH counts), then restart in RUN with PERIOD=1
    kick(1'b1, 8'd0, c);
    chk8("t5_p0_d", D, 8'h00);
    exp_q.push_back(c + 2 + 256*PS);
    exp_q.push_back(c + 2 + 512*PS);
    go_to(c + 3 + 512*PS);
    drained("t5_p0_ticks");
    kick(1'b1, 8'd1, c);
    chk8("t5_p1_d",     D,    8'hFF);
    chk1("t5_p1_pe_n",  PE_N, 1'b0);
    chk1("t5_p1_busy",  BUSY, 1'b1);
    for (int i = 0; i < 8; i++) exp_q.push_back(c + 2 + PS*(1 + i));
    last = c + 2 + 8*PS;
    go_to(last);
    HOLD = 1'b1;
    STOP = 1'b1;
    step();
    HOLD = 1'b0;
    STOP = 1'b0;
    chk1("t5_stop_busy",  BUSY,  1'b0);
    chk1("t5_stop_clr_n", CLR_N, 1'b0);
    go_to(cyc + 5);
    drained("t5_p1_ticks");

    // Board reset in the middle of RUN, while TICK is high
    kick(1'b1, 8'd5, c);
    t = c + 2 + 5*PS;
    go_to(t);
    chk1("t6_pre_tick", TICK, 1'b1);
    chk1("t6_pre_busy", BUSY, 1'b1);
    MR_N = 1'b0;
    #1 chk_reset_vals("t6_mid_reset");
    step();
    step();
    MR_N = 1'b1;
    step();
    chk1("t6_after_busy",  BUSY,  1'b0);
    chk1("t6_after_clr_n", CLR_N, 1'b1);
    go_to(cyc + 10);
    drained("t6_ticks");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/w_161_timer_ctrl.md
Name: w_161_timer_ctrl

Overview:
- Sequencing controller for a chain of the team's 74HC161-compatible 4-bit synchronous counters, cascaded through TC→CET into a WIDTH-bit up counter.
- Drives the chain's shared PE_N, CEP, CET, D and clear, and watches the chain's final TC.
- Turns the counter chain into a programmable-period timer with one-shot and auto-reload modes, hold, and a tick/done output.
- Sits between the board-level control logic and the counter datapath.

Parameters:
NIBBLES, 2, number of cascaded 4-bit counters; WIDTH = 4*NIBBLES
PRESCALE, 4, CEP divide ratio; used only when W161_CTRL_PRESCALE_EN is defined; legal range 1..255

Ports:
CP  in  1  clock; rising edge active
MR_N  in  1  asynchronous active-low reset
START  in  1  level-sampled; starts or restarts the timer
STOP  in  1  level-sampled; aborts to IDLE
HOLD  in  1  pauses counting while in RUN
MODE  in  1  0 = one-shot, 1 = auto-reload
PERIOD  in  WIDTH  period in counts; 0 means 2^WIDTH
TC_IN  in  1  TC of the most-significant counter in the chain
PE_N  out  1  parallel-enable to all counters, active low
CEP  out  1  count-enable-parallel to all counters
CET  out  1  count-enable-trickle to the least-significant counter
D  out  WIDTH  parallel load value
CLR_N  out  1  to counter MR_N; registered, active low
TICK  out  1  one-cycle pulse per expiry
DONE  out  1  one-shot finished
BUSY  out  1  high in LOAD or RUN

Behaviour:
- Single clock CP. Reset MR_N is asynchronous, active-low. All state and registered outputs clear immediately on MR_N=0.
- Reset values: PE_N=1, CEP=0, CET=0, D=0, CLR_N=1, TICK=0, DONE=0, BUSY=0, state=IDLE, PER_R=0.
- States and transitions:
  - IDLE → LOAD on START.
  - LOAD → RUN always after one cycle.
  - RUN → LOAD on START.
  - RUN → RUN on expiry with MODE=1.
  - RUN → DONE on expiry with MODE=0.
  - DONE → LOAD on START.
  - Any state → IDLE on STOP. STOP has priority over START.
- START in IDLE, RUN or DONE latches PERIOD into PER_R.
- D = (2^WIDTH − PER_R) mod 2^WIDTH, combinational from PER_R.
- LOAD: PE_N=0, CEP=0, CET=0. The chain loads D at the next edge.
- RUN:
  - CET=1; CEP = ~HOLD (ANDed with prescale strobe when the feature is enabled).
  - Expiry = TC_IN & CEP.
  - PE_N = ~(Expiry & MODE), combinational, so the reload overrides the wrap at the same edge.
  - In one-shot mode the chain wraps on the expiry edge, but it is frozen in DONE, so the value is irrelevant.
- DONE/IDLE: PE_N=1, CEP=0, CET=0; counter value held.
- TICK: registered; high for the one cycle after each expiry edge.
- DONE output: registered; set with the transition to DONE; cleared on entry to LOAD or IDLE.
- CLR_N: registered; low for exactly one cycle after any transition into IDLE caused by STOP.
- Timing: period = PER_R cycles of enabled CEP. START sampled at edge k → counter loaded at edge k+1 → first expiry at edge k+1+PER_R → TICK high in the following cycle.
- PERIOD=1: D = all-ones; expiry every enabled cycle; TICK continuous in auto-reload.
- PERIOD=0: D=0; 2^WIDTH-cycle period.
- HOLD:
  - HOLD=1 in RUN freezes the counter; TC_IN may be high (TC depends on CET only) but no expiry occurs.
  - HOLD is ignored outside RUN.
  - HOLD released at value all-ones expires on the first enabled cycle.
- Reset mid-RUN: immediate IDLE; the counter's own MR_N is board-driven, and CLR_N is not pulsed by reset.

Optional Feature:
- Macro W161_CTRL_PRESCALE_EN.
- When defined:
  - A free-running modulo-PRESCALE counter runs only in RUN with HOLD=0; it is cleared in other states and frozen while HOLD=1.
  - The prescale strobe is high on the count of PRESCALE−1. CEP = ~HOLD & strobe.
  - Period = PER_R*PRESCALE cycles.
  - The prescale counter resets to 0 on LOAD entry.
- When undefined: no prescale logic; CEP = ~HOLD in RUN.

Test Plan:
- MODE=1, PERIOD=5, START one cycle → LOAD one cycle with D=0xFB, PE_N=0. TICK pulses at cycles 7, 12, 17 after the START edge. PE_N=0 in each cycle where Q=0xFF.
- MODE=0, PERIOD=3 → single TICK at cycle 5. DONE=1 from cycle 5 onward. CEP=CET=0 afterwards. START then restarts with DONE cleared.
- MODE=1, PERIOD=10, HOLD=1 for 4 cycles mid-count → tick interval extends from 10 to 14 cycles. No TICK while held at Q=0xFF.
- START and STOP asserted in the same cycle during RUN → IDLE, CLR_N low for exactly one cycle, BUSY=0, no TICK.
- PERIOD=0 and PERIOD=1, MODE=1 → TICK every 256 cycles for PERIOD=0. TICK continuous high with D=0xFF for PERIOD=1.
- With W161_CTRL_PRESCALE_EN and PRESCALE=4, PERIOD=3 → TICK every 12 cycles. MR_N pulsed low mid-RUN → all outputs return to reset values immediately.
